// File: rtl/event_sync_pkg.sv
// Shared helpers for the toggle-event receiver: id width and counter ceiling.
package event_sync_pkg;

    function automatic int idw(input int ch);
        return (ch <= 2) ? 1 : $clog2(ch);
    endfunction

    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/toggle_sync_ch.sv
// One channel: synchroniser chain, history flop and single-cycle edge output.
// SYNC_FILTER_EN adds a stage and only accepts a level once two stages agree.
module toggle_sync_ch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tog,
    output logic evt
);

`ifdef SYNC_FILTER_EN
    localparam int N = SYNC_STAGES + 1;
`else
    localparam int N = SYNC_STAGES;
`endif

    logic [N-1:0] sync;
    logic         hist;

`ifdef SYNC_FILTER_EN
    logic agree;
    assign agree = (sync[N-1] == sync[N-2]);
    assign evt   = agree & (sync[N-1] ^ hist);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[N-2:0], tog};
            // history follows only a level that held across the last two stages
            if (agree) hist <= sync[N-1];
        end
    end
`else
    assign evt = sync[N-1] ^ hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[N-2:0], tog};
            hist <= sync[N-1];
        end
    end
`endif

endmodule

// File: rtl/event_sync_rx.sv
// Multi-channel toggle-event receiver: per-channel pending counters drained
// through a round-robin registered valid/ready port. Option: SYNC_FILTER_EN.
module event_sync_rx
    import event_sync_pkg::*;
#(
    parameter  int CH          = 4,
    parameter  int SYNC_STAGES = 2,
    parameter  int CNT_W       = 3,
    localparam int IDW         = idw(CH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [CH-1:0]  tog_in,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [IDW-1:0] evt_id,
    output logic [CH-1:0]  pend,
    output logic [CH-1:0]  ovf,
    input  logic [CH-1:0]  ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CH-1:0]    edge_v;
    logic [CH-1:0]    grant;
    logic [CNT_W-1:0] cnt [CH];
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   sel;
    logic [IDW-1:0]   nxt;
    logic             found;
    logic             load;

    for (genvar g = 0; g < CH; g++) begin : g_sync
        toggle_sync_ch #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .tog   (tog_in[g]),
            .evt   (edge_v[g])
        );
    end

    assign load = !evt_valid || evt_ready;

    always_comb begin
        for (int unsigned i = 0; i < CH; i++) pend[i] = (cnt[i] != '0);
    end

    // Round-robin: scan ptr..CH-1 first, then wrap to 0..ptr-1.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (!found && i >= 32'(ptr) && pend[i]) begin
                found = 1'b1;
                sel   = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < CH; i++) begin
            if (!found && i < 32'(ptr) && pend[i]) begin
                found = 1'b1;
                sel   = IDW'(i);
            end
        end
        nxt   = (32'(sel) == 32'(CH - 1)) ? '0 : sel + 1'b1;
        grant = '0;
        if (load && found) grant[sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CH; i++) cnt[i] <= '0;
            ovf       <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            ptr       <= '0;
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                // clear first so a same-cycle overflow below takes precedence
                if (ovf_clr[i]) ovf[i] <= 1'b0;
                if (edge_v[i] && !grant[i]) begin
                    if (cnt[i] == CNT_MAX) ovf[i] <= 1'b1;
                    else                   cnt[i] <= cnt[i] + 1'b1;
                end else if (!edge_v[i] && grant[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
            if (load) begin
                evt_valid <= found;
                if (found) begin
                    evt_id <= sel;
                    ptr    <= nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_event_sync_rx.sv
// Directed self-checking bench for event_sync_rx (CH=4, SYNC_STAGES=2, CNT_W=3).
module tb_event_sync_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] tog_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic [3:0] pend;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;

    int total = 0;
    int bad   = 0;
    int got_ids[$];
    int n;

`ifdef SYNC_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    always #5 clk = ~clk;

    event_sync_rx #(.CH(4), .SYNC_STAGES(2), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tog_in    (tog_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .pend      (pend),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        tog_in    = '0;
        ovf_clr   = '0;
        evt_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Record the id of every handshake over a fixed window of cycles.
    task automatic drain(input int cycles, output int cnt);
        got_ids.delete();
        for (int c = 0; c < cycles; c++) begin
            if (evt_valid && evt_ready) got_ids.push_back(int'(evt_id));
            tick();
        end
        cnt = got_ids.size();
    endtask

    task automatic chk_ids(input string tag, input int exp[$]);
        chk({tag, "_n"}, got_ids.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(tag, (i < got_ids.size()) ? got_ids[i] : -1, exp[i]);
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_id",    int'(evt_id),    0);
        chk("rst_pend",  int'(pend),      0);
        chk("rst_ovf",   int'(ovf),       0);

        // single event latency on ch2
        tog_in[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("lat_e0", int'(evt_valid), 0);
        for (int i = 1; i < LAT; i++) begin
            tick();
            chk("lat_wait", int'(evt_valid), 0);
            if (i == LAT - 1) chk("lat_pend", int'(pend), 4);
        end
        tick();
        chk("lat_valid", int'(evt_valid), 1);
        chk("lat_id",    int'(evt_id),    2);
        chk("lat_pend0", int'(pend),      0);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("hs_valid", int'(evt_valid), 0);
        chk("hs_pend",  int'(pend),      0);

        // all channels at once, then round-robin mix
        do_reset();
        evt_ready = 1'b1;
        fork
            tog_in = 4'hF;
            drain(20, n);
        join
        chk_ids("rr_all", '{0, 1, 2, 3});
        fork
            begin
                tog_in[1] = ~tog_in[1];
                tog_in[3] = ~tog_in[3];
                tick(); tick();
                tog_in[1] = ~tog_in[1];
                tick(); tick();
                tog_in[1] = ~tog_in[1];
            end
            drain(24, n);
        join
        chk_ids("rr_mix", '{1, 3, 1, 1});

        // saturation and overflow on ch0 with back-pressure
        evt_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tog_in[0] = ~tog_in[0];
            tick(); tick();
        end
        repeat (6) tick();
        chk("ovf_set",   int'(ovf[0]),    1);
        chk("ovf_pend",  int'(pend),      1);
        chk("ovf_valid", int'(evt_valid), 1);
        chk("ovf_id",    int'(evt_id),    0);
        ovf_clr[0] = 1'b1;
        tick();
        ovf_clr[0] = 1'b0;
        chk("ovf_clr", int'(ovf[0]), 0);

        // increment and grant in the same cycle at count 7
        tog_in[0] = ~tog_in[0];
        tick();             // after E0
        tick();             // after E0+1, edge visible now
        evt_ready = 1'b1;
        tick();             // E0+2: inc and dec together
        chk("incdec_ovf",   int'(ovf[0]),    0);
        chk("incdec_valid", int'(evt_valid), 1);
        chk("incdec_id",    int'(evt_id),    0);
        drain(20, n);
        chk("sat_drain", n, 8);
        chk("sat_pend",  int'(pend), 0);
        chk("sat_ovf",   int'(ovf),  0);

        // asynchronous reset in the middle of a burst
        do_reset();
        tog_in = 4'hF;
        repeat (6) tick();
        chk("mid_valid", int'(evt_valid), 1);
        chk("mid_pend",  int'(pend),      4'hE);
        #2;
        rst_n  = 1'b0;
        tog_in = '0;
        #1;
        chk("arst_valid", int'(evt_valid), 0);
        chk("arst_id",    int'(evt_id),    0);
        chk("arst_pend",  int'(pend),      0);
        chk("arst_ovf",   int'(ovf),       0);
        tick();
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        drain(20, n);
        chk("arst_quiet", n, 0);

`ifdef SYNC_FILTER_EN
        // one-cycle glitch must not produce an event
        do_reset();
        tog_in[1] = 1'b1;
        tick();
        tog_in[1] = 1'b0;
        repeat (10) tick();
        chk("flt_valid", int'(evt_valid), 0);
        chk("flt_pend",  int'(pend),      0);
        chk("flt_ovf",   int'(ovf),       0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
